// File: rtl/spi_byte_master.sv
// Byte-level SPI master, mode 0, MSB first; cs_n stays low between bytes until released.
// Optional HOLD idle timeout enabled by defining SPI_CS_IDLE_TIMEOUT_EN.
module spi_byte_master #(
    parameter int unsigned CLK_DIV         = 2,
    parameter int unsigned CS_SETUP_CYC    = 2,
    parameter int unsigned CS_IDLE_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_i,
    input  logic [7:0] tx_byte_i,
    input  logic       cs_release_i,
    output logic [7:0] rx_byte_o,
    output logic       done_o,
    output logic       busy_o,
    output logic       spi_sck_o,
    output logic       spi_mosi_o,
    input  logic       spi_miso_i,
    output logic       spi_cs_n_o
);

    localparam int unsigned DivW   = $clog2(CLK_DIV + 1);
    localparam int unsigned SetupW = $clog2(CS_SETUP_CYC + 1);
    localparam logic [DivW-1:0]   DivLast   = DivW'(CLK_DIV - 1);
    localparam logic [SetupW-1:0] SetupLast = SetupW'(CS_SETUP_CYC - 1);

    if (CLK_DIV < 1 || CS_SETUP_CYC < 1 || CS_IDLE_TIMEOUT < 1) begin : g_bad_param
        $error("spi_byte_master: CLK_DIV, CS_SETUP_CYC and CS_IDLE_TIMEOUT must be >= 1");
    end

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StLow,
        StHigh,
        StHold
    } state_e;

    state_e              state_q;
    logic [DivW-1:0]     div_q;
    logic [SetupW-1:0]   setup_q;
    logic [2:0]          bit_q;
    logic [7:0]          shreg_q;

`ifdef SPI_CS_IDLE_TIMEOUT_EN
    localparam int unsigned HoldW = $clog2(CS_IDLE_TIMEOUT + 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(CS_IDLE_TIMEOUT - 1);
    logic [HoldW-1:0] hold_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            div_q      <= '0;
            setup_q    <= '0;
            bit_q      <= 3'd0;
            shreg_q    <= 8'h00;
            rx_byte_o  <= 8'h00;
            done_o     <= 1'b0;
            busy_o     <= 1'b0;
            spi_sck_o  <= 1'b0;
            spi_mosi_o <= 1'b0;
            spi_cs_n_o <= 1'b1;
`ifdef SPI_CS_IDLE_TIMEOUT_EN
            hold_q     <= '0;
`endif
        end else begin
            done_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        shreg_q    <= tx_byte_i;
                        spi_mosi_o <= tx_byte_i[7];
                        spi_cs_n_o <= 1'b0;
                        busy_o     <= 1'b1;
                        setup_q    <= '0;
                        state_q    <= StSetup;
                    end
                end
                StSetup: begin
                    if (setup_q == SetupLast) begin
                        setup_q <= '0;
                        div_q   <= '0;
                        state_q <= StLow;
                    end else begin
                        setup_q <= setup_q + 1'b1;
                    end
                end
                StLow: begin
                    if (div_q == DivLast) begin
                        div_q     <= '0;
                        spi_sck_o <= 1'b1;
                        shreg_q   <= {shreg_q[6:0], spi_miso_i};
                        state_q   <= StHigh;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                StHigh: begin
                    if (div_q == DivLast) begin
                        div_q     <= '0;
                        spi_sck_o <= 1'b0;
                        bit_q     <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            rx_byte_o <= shreg_q;
                            done_o    <= 1'b1;
                            busy_o    <= 1'b0;
                            state_q   <= StHold;
`ifdef SPI_CS_IDLE_TIMEOUT_EN
                            hold_q    <= '0;
`endif
                        end else begin
                            // Shift register already moved left on the rising edge.
                            spi_mosi_o <= shreg_q[7];
                            state_q    <= StLow;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                StHold: begin
                    if (start_i) begin
                        shreg_q    <= tx_byte_i;
                        spi_mosi_o <= tx_byte_i[7];
                        busy_o     <= 1'b1;
                        div_q      <= '0;
                        state_q    <= StLow;
                    end else if (cs_release_i) begin
                        spi_cs_n_o <= 1'b1;
                        spi_mosi_o <= 1'b0;
                        state_q    <= StIdle;
                    end
`ifdef SPI_CS_IDLE_TIMEOUT_EN
                    else if (hold_q == HoldLast) begin
                        spi_cs_n_o <= 1'b1;
                        spi_mosi_o <= 1'b0;
                        state_q    <= StIdle;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_byte_master.sv
// Scoreboard bench for spi_byte_master: stimulus pushes expected bytes/latency, monitor checks on done_o.
module tb_spi_byte_master;

    localparam int CLK_DIV  = 2;
    localparam int SETUP    = 2;
    localparam int TIMEOUT  = 8;

    logic       clk;
    logic       reset_n;
    logic       start_i;
    logic [7:0] tx_byte_i;
    logic       cs_release_i;
    logic [7:0] rx_byte_o;
    logic       done_o;
    logic       busy_o;
    logic       spi_sck_o;
    logic       spi_mosi_o;
    logic       spi_miso_i;
    logic       spi_cs_n_o;

    spi_byte_master #(
        .CLK_DIV        (CLK_DIV),
        .CS_SETUP_CYC   (SETUP),
        .CS_IDLE_TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_i     (start_i),
        .tx_byte_i   (tx_byte_i),
        .cs_release_i(cs_release_i),
        .rx_byte_o   (rx_byte_o),
        .done_o      (done_o),
        .busy_o      (busy_o),
        .spi_sck_o   (spi_sck_o),
        .spi_mosi_o  (spi_mosi_o),
        .spi_miso_i  (spi_miso_i),
        .spi_cs_n_o  (spi_cs_n_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        int         done_edge;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         checks = 0;
    int         errors = 0;
    int         edge_n = 0;
    int         done_cnt = 0;
    int         sck_rises = 0;
    int         cs_rises = 0;
    logic       sck_prev = 1'b0;
    logic       cs_prev = 1'b1;
    logic [7:0] miso_sh = 8'h00;
    logic [7:0] mosi_cap = 8'h00;

    assign spi_miso_i = miso_sh[7];

    always @(posedge clk) edge_n++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", name, act, exp);
        end
    endtask

    // Mode-0 flash model: present next MISO bit and capture MOSI after each rising SCK.
    always @(negedge clk) begin
        if (spi_sck_o && !sck_prev) begin
            mosi_cap = {mosi_cap[6:0], spi_mosi_o};
            miso_sh  = {miso_sh[6:0], 1'b0};
            sck_rises++;
        end
        if (spi_cs_n_o && !cs_prev) cs_rises++;
        sck_prev = spi_sck_o;
        cs_prev  = spi_cs_n_o;
    end

    always @(negedge clk) begin
        if (done_o) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done at edge %0d rx %0h", edge_n, rx_byte_o);
            end else begin
                e = sb.pop_front();
                check("rx_byte", {24'h0, rx_byte_o}, {24'h0, e.rx});
                check("mosi_byte", {24'h0, mosi_cap}, {24'h0, e.tx});
                check("done_edge", edge_n, e.done_edge);
            end
        end
    end

    // Call at a negedge; returns at the next negedge with start deasserted.
    task automatic issue(input logic [7:0] tx, input logic [7:0] srx, input int s);
        exp_t x;
        start_i   = 1'b1;
        tx_byte_i = tx;
        miso_sh   = srx;
        x.tx        = tx;
        x.rx        = srx;
        x.done_edge = edge_n + 1 + s + 16 * CLK_DIV;
        sb.push_back(x);
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_o && n < budget);
        if (!done_o) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual none after %0d cycles required done_o", n);
        end
    endtask

    initial begin
        int base;
        int n;
        reset_n      = 1'b0;
        start_i      = 1'b0;
        tx_byte_i    = 8'h00;
        cs_release_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sck", {31'h0, spi_sck_o}, 32'h0);
        check("rst_cs_n", {31'h0, spi_cs_n_o}, 32'h1);
        check("rst_mosi", {31'h0, spi_mosi_o}, 32'h0);
        check("rst_done", {31'h0, done_o}, 32'h0);
        check("rst_busy", {31'h0, busy_o}, 32'h0);
        check("rst_rx", {24'h0, rx_byte_o}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // First byte from IDLE, then three bytes issued in each done cycle.
        issue(8'h03, 8'hA5, SETUP);
        wait_done(100);
        check("cs_held", {31'h0, spi_cs_n_o}, 32'h0);
        base = cs_rises;
        issue(8'h00, 8'h3C, 0);
        wait_done(100);
        issue(8'h81, 8'hC3, 0);
        wait_done(100);
        issue(8'h7E, 8'h5A, 0);
        wait_done(100);
        check("cs_no_glitch", cs_rises - base, 32'h0);

        cs_release_i = 1'b1;
        @(negedge clk);
        cs_release_i = 1'b0;
        check("cs_release", {31'h0, spi_cs_n_o}, 32'h1);

        // Start/release requests while busy must be ignored.
        issue(8'h9F, 8'h01, SETUP);
        repeat (4) @(negedge clk);
        check("busy_mid", {31'h0, busy_o}, 32'h1);
        for (int i = 0; i < 10; i++) begin
            start_i      = 1'b1;
            tx_byte_i    = 8'(i * 37 + 5);
            cs_release_i = (i == 3);
            @(negedge clk);
        end
        start_i      = 1'b0;
        cs_release_i = 1'b0;
        check("cs_busy_release_ignored", {31'h0, spi_cs_n_o}, 32'h0);
        wait_done(100);

`ifdef SPI_CS_IDLE_TIMEOUT_EN
        repeat (TIMEOUT - 1) @(negedge clk);
        check("timeout_early", {31'h0, spi_cs_n_o}, 32'h0);
        @(negedge clk);
        check("timeout_release", {31'h0, spi_cs_n_o}, 32'h1);
`else
        base = cs_rises;
        repeat (100) @(negedge clk);
        check("no_timeout_rise", cs_rises - base, 32'h0);
        check("no_timeout_cs", {31'h0, spi_cs_n_o}, 32'h0);
        cs_release_i = 1'b1;
        @(negedge clk);
        cs_release_i = 1'b0;
        check("cs_release2", {31'h0, spi_cs_n_o}, 32'h1);
`endif

        // Reset after three rising SCK edges abandons the byte.
        base = sck_rises;
        issue(8'h55, 8'hAA, SETUP);
        n = 0;
        while (sck_rises - base < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL sck_timeout actual %0d rises required 3", sck_rises - base);
        end
        reset_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midrst_sck", {31'h0, spi_sck_o}, 32'h0);
        check("midrst_cs_n", {31'h0, spi_cs_n_o}, 32'h1);
        check("midrst_busy", {31'h0, busy_o}, 32'h0);
        check("midrst_done", {31'h0, done_o}, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        base = done_cnt;
        repeat (60) @(negedge clk);
        check("no_done_after_reset", done_cnt - base, 32'h0);

        issue(8'hC3, 8'h96, SETUP);
        wait_done(100);
        @(negedge clk);
        check("sb_empty", sb.size(), 32'h0);
        check("done_count", done_cnt, 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
